// File: rtl/alu_src_b_pkg.sv
// Shared operand-B select codes and skid-buffer state encoding.
// The control unit imports this package for the same select codes.
package alu_src_b_pkg;

  localparam int SEL_W = 3;

  typedef enum logic [SEL_W-1:0] {
    SRC_B_REG      = 3'b000,
    SRC_B_CONST    = 3'b001,
    SRC_B_SEXT     = 3'b010,
    SRC_B_SEXT_SL2 = 3'b011,
    SRC_B_ZEXT     = 3'b100,
    SRC_B_LUI      = 3'b101,
    SRC_B_FWD0     = 3'b110,
    SRC_B_FWD1     = 3'b111
  } src_b_sel_e;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'b00,
    SKID_HALF  = 2'b01,
    SKID_FULL  = 2'b10
  } skid_state_e;

endpackage

// File: rtl/pipe_skid_buffer.sv
// Generic valid/ready pipeline register with one skid entry; main register
// drives the outputs, the skid entry absorbs one beat while the consumer stalls.
module pipe_skid_buffer
  import alu_src_b_pkg::*;
#(
  parameter int DATA_WIDTH = 35
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i
);

  skid_state_e           state_q, state_d;
  logic [DATA_WIDTH-1:0] main_q, main_d;
  logic [DATA_WIDTH-1:0] skid_q, skid_d;
  logic                  in_xfer, out_xfer;

  // Ready depends only on the state register, never on out_ready_i.
  assign in_ready_o  = (state_q != SKID_FULL);
  assign out_valid_o = (state_q != SKID_EMPTY);
  assign out_data_o  = main_q;

  assign in_xfer  = in_valid_i & in_ready_o;
  assign out_xfer = out_valid_o & out_ready_i;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      SKID_EMPTY: begin
        if (in_xfer) begin
          main_d  = in_data_i;
          state_d = SKID_HALF;
        end
      end
      SKID_HALF: begin
        if (in_xfer && out_xfer) begin
          main_d = in_data_i;
        end else if (in_xfer) begin
          skid_d  = in_data_i;
          state_d = SKID_FULL;
        end else if (out_xfer) begin
          state_d = SKID_EMPTY;
        end
      end
      SKID_FULL: begin
        if (out_xfer) begin
          main_d  = skid_q;
          skid_d  = '0;
          state_d = SKID_HALF;
        end
      end
      default: state_d = SKID_EMPTY;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= SKID_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: rtl/alu_src_b_stage.sv
// ALU operand-B selector: combinational source/immediate selection feeding a
// registered valid/ready stage so the ALU can stall without losing operands.
module alu_src_b_stage
  import alu_src_b_pkg::*;
#(
  parameter int          WIDTH     = 32,
  parameter int          IMM_WIDTH = 16,
  parameter int unsigned CONST_VAL = 4,
  parameter int          NUM_FWD   = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [SEL_W-1:0]     sel,
  input  logic [WIDTH-1:0]     reg_b,
  input  logic [IMM_WIDTH-1:0] imm,
  input  logic [2*WIDTH-1:0]   fwd_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [SEL_W-1:0]     out_sel,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 sel_err
);

  logic [WIDTH-1:0]       imm_sext, imm_zext, fwd0, fwd1, operand;
  logic [WIDTH+SEL_W-1:0] buf_out;
  logic                   absent_src;
  logic                   sel_err_q, sel_err_d;

  assign imm_sext = {{(WIDTH-IMM_WIDTH){imm[IMM_WIDTH-1]}}, imm};
  assign imm_zext = {{(WIDTH-IMM_WIDTH){1'b0}}, imm};
  assign fwd0     = (NUM_FWD >= 1) ? fwd_data[WIDTH-1:0]       : '0;
  assign fwd1     = (NUM_FWD >= 2) ? fwd_data[2*WIDTH-1:WIDTH] : '0;

  always_comb begin
    operand    = '0;
    absent_src = 1'b0;
    case (sel)
      SRC_B_REG:      operand = reg_b;
      SRC_B_CONST:    operand = WIDTH'(CONST_VAL);
      SRC_B_SEXT:     operand = imm_sext;
      SRC_B_SEXT_SL2: operand = imm_sext << 2;
      SRC_B_ZEXT:     operand = imm_zext;
      SRC_B_LUI:      operand = imm_zext << 16;
      SRC_B_FWD0: begin
        operand    = fwd0;
        absent_src = (NUM_FWD < 1);
      end
      SRC_B_FWD1: begin
        operand    = fwd1;
        absent_src = (NUM_FWD < 2);
      end
      default:        operand = '0;
    endcase
  end

  // Sticky flag: only an accepted transfer can raise it, only reset clears it.
  assign sel_err_d = sel_err_q | (in_valid & in_ready & absent_src);
  assign sel_err   = sel_err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sel_err_q <= 1'b0;
    else        sel_err_q <= sel_err_d;
  end

  pipe_skid_buffer #(
    .DATA_WIDTH(WIDTH + SEL_W)
  ) u_skid (
    .clk_i      (clk),
    .rst_ni     (reset),
    .in_data_i  ({sel, operand}),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .out_data_o (buf_out),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready)
  );

  assign {out_sel, out_data} = buf_out;

endmodule

// File: tb/tb_alu_src_b_stage.sv
// Self-checking bench for alu_src_b_stage: two instances (NUM_FWD 2 and 1)
// share stimulus and are compared against a queue-based reference model.
module tb_alu_src_b_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  sel;
  logic [31:0] reg_b;
  logic [15:0] imm;
  logic [63:0] fwd_data;
  logic        in_valid, out_ready;

  logic        in_ready, out_valid, sel_err;
  logic [31:0] out_data;
  logic [2:0]  out_sel;
  logic        in_ready1, out_valid1, sel_err1;
  logic [31:0] out_data1;
  logic [2:0]  out_sel1;

  int tests = 0;
  int fails = 0;

  logic [34:0] q[$];
  logic [34:0] q1[$];
  logic        err1_m = 1'b0;

  always #5 clk = ~clk;

  alu_src_b_stage #(.WIDTH(32), .IMM_WIDTH(16), .CONST_VAL(4), .NUM_FWD(2)) dut (
    .clk(clk), .reset(reset), .sel(sel), .reg_b(reg_b), .imm(imm), .fwd_data(fwd_data),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data), .out_sel(out_sel),
    .out_valid(out_valid), .out_ready(out_ready), .sel_err(sel_err));

  alu_src_b_stage #(.WIDTH(32), .IMM_WIDTH(16), .CONST_VAL(4), .NUM_FWD(1)) dut1 (
    .clk(clk), .reset(reset), .sel(sel), .reg_b(reg_b), .imm(imm), .fwd_data(fwd_data),
    .in_valid(in_valid), .in_ready(in_ready1), .out_data(out_data1), .out_sel(out_sel1),
    .out_valid(out_valid1), .out_ready(out_ready), .sel_err(sel_err1));

  function automatic logic [31:0] ref_op(input logic [2:0] s, input logic [31:0] rb,
                                         input logic [15:0] im, input logic [63:0] fw,
                                         input int nf);
    logic signed [15:0] ims;
    logic signed [31:0] sx;
    ims = im;
    sx  = ims;
    case (s)
      3'd0: return rb;
      3'd1: return 32'd4;
      3'd2: return sx;
      3'd3: return 32'(sx * 4);
      3'd4: return 32'(im);
      3'd5: return 32'(32'(im) * 65536);
      3'd6: return (nf >= 1) ? fw[31:0] : 32'd0;
      default: return (nf >= 2) ? fw[63:32] : 32'd0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("in_ready", in_ready, q.size() < 2);
    chk("out_valid", out_valid, q.size() > 0);
    chk("in_ready1", in_ready1, q1.size() < 2);
    chk("out_valid1", out_valid1, q1.size() > 0);
    chk("sel_err", sel_err, 1'b0);
    chk("sel_err1", sel_err1, err1_m);
    if (q.size() > 0) begin
      chk("out_data", out_data, q[0][31:0]);
      chk("out_sel", out_sel, q[0][34:32]);
    end
    if (q1.size() > 0) begin
      chk("out_data1", out_data1, q1[0][31:0]);
      chk("out_sel1", out_sel1, q1[0][34:32]);
    end
  endtask

  // One clock: drive inputs, advance the model at the edge, check 1 time unit later.
  task automatic cyc(input logic v, input logic [2:0] s, input logic [31:0] rb,
                     input logic [15:0] im, input logic [63:0] fw, input logic ordy);
    bit ix, ox;
    in_valid = v; sel = s; reg_b = rb; imm = im; fwd_data = fw; out_ready = ordy;
    @(posedge clk);
    ix = v && (q.size() < 2);
    ox = ordy && (q.size() > 0);
    if (ox) begin
      void'(q.pop_front());
      void'(q1.pop_front());
    end
    if (ix) begin
      q.push_back({s, ref_op(s, rb, im, fw, 2)});
      q1.push_back({s, ref_op(s, rb, im, fw, 1)});
      if (s == 3'd7) err1_m = 1'b1;
    end
    #1 check_all();
  endtask

  initial begin
    logic [63:0] fw;
    logic        hv;
    logic [2:0]  hs;
    logic [31:0] hrb;
    logic [15:0] him;
    logic [63:0] hfw;
    fw = 64'hCAFE_0001_1234_5678;
    reset = 1'b0; in_valid = 1'b0; sel = '0; reg_b = '0; imm = '0; fwd_data = '0; out_ready = 1'b0;
    #12;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_sel", out_sel, 3'd0);
    chk("rst_sel_err", sel_err, 1'b0);
    reset = 1'b1;

    // Select sweep with known constants
    cyc(1, 3'd2, 32'h0, 16'h8001, fw, 1); chk("sext", out_data, 32'hFFFF8001);
    cyc(1, 3'd3, 32'h0, 16'h8001, fw, 1); chk("sext_sl2", out_data, 32'hFFFE0004);
    cyc(1, 3'd4, 32'h0, 16'h8001, fw, 1); chk("zext", out_data, 32'h00008001);
    cyc(1, 3'd5, 32'h0, 16'h8001, fw, 1); chk("lui", out_data, 32'h80010000);
    cyc(1, 3'd1, 32'h0, 16'h8001, fw, 1); chk("const", out_data, 32'h00000004);
    cyc(1, 3'd0, 32'hDEAD_BEEF, 16'h8001, fw, 1); chk("reg_b", out_data, 32'hDEAD_BEEF);
    cyc(1, 3'd6, 32'h0, 16'h0, fw, 1); chk("fwd0", out_data1, 32'h1234_5678);
    cyc(1, 3'd7, 32'h0, 16'h0, fw, 1);
    chk("fwd1", out_data, 32'hCAFE_0001);
    chk("fwd1_absent", out_data1, 32'd0);
    chk("sel_err1_set", sel_err1, 1'b1);
    cyc(1, 3'd0, 32'h11, 16'h0, fw, 1);
    chk("sel_err1_sticky", sel_err1, 1'b1);
    cyc(0, 3'd0, 32'h0, 16'h0, fw, 1);

    // Streaming: 8 back-to-back operands
    for (int i = 0; i < 8; i++) cyc(1, 3'd0, 32'h100 + i, 16'h0, fw, 1);
    cyc(0, 3'd0, 32'h0, 16'h0, fw, 1);

    // Backpressure: A, B accepted, C held until room appears
    cyc(1, 3'd0, 32'hA, 16'h0, fw, 0);
    cyc(1, 3'd0, 32'hB, 16'h0, fw, 0);
    chk("bp_full_ready", in_ready, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1, 3'd0, 32'hC, 16'h0, fw, 0);
    chk("bp_hold_a", out_data, 32'hA);
    cyc(1, 3'd0, 32'hC, 16'h0, fw, 1);
    chk("bp_b_next", out_data, 32'hB);
    cyc(1, 3'd0, 32'hC, 16'h0, fw, 1);
    chk("bp_c_next", out_data, 32'hC);
    cyc(0, 3'd0, 32'h0, 16'h0, fw, 1);

    // Simultaneous in/out in HALF
    cyc(1, 3'd0, 32'h55, 16'h0, fw, 0);
    cyc(1, 3'd0, 32'h66, 16'h0, fw, 1);
    chk("half_swap_data", out_data, 32'h66);
    chk("half_swap_ready", in_ready, 1'b1);
    cyc(0, 3'd0, 32'h0, 16'h0, fw, 1);

    // Randomized traffic; producer holds an offer until it is accepted
    hv = 1'b0; hs = '0; hrb = '0; him = '0; hfw = '0;
    for (int i = 0; i < 300; i++) begin
      logic acc;
      if (!hv) begin
        hv  = ($urandom_range(0, 3) != 0);
        hs  = 3'($urandom_range(0, 7));
        hrb = $urandom;
        him = 16'($urandom);
        hfw = {$urandom, $urandom};
      end
      acc = hv && (q.size() < 2);
      cyc(hv, hs, hrb, him, hfw, ($urandom_range(0, 2) != 0));
      if (acc) hv = 1'b0;
    end

    // Reset asserted mid-cycle while FULL and stalled
    cyc(0, 3'd0, 32'h0, 16'h0, fw, 1);
    cyc(0, 3'd0, 32'h0, 16'h0, fw, 1);
    cyc(1, 3'd0, 32'h77, 16'h0, fw, 0);
    cyc(1, 3'd7, 32'h88, 16'h0, fw, 0);
    chk("pre_rst_full", in_ready, 1'b0);
    in_valid = 1'b0;
    #3 reset = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 1'b0);
    chk("arst_in_ready", in_ready, 1'b1);
    chk("arst_sel_err1", sel_err1, 1'b0);
    chk("arst_out_data", out_data, 32'd0);
    chk("arst_out_sel", out_sel, 3'd0);
    q.delete(); q1.delete(); err1_m = 1'b0;
    @(posedge clk); @(posedge clk);
    #2 reset = 1'b1;
    cyc(1, 3'd1, 32'h0, 16'h0, fw, 0);
    chk("post_rst_data", out_data, 32'd4);
    cyc(0, 3'd0, 32'h0, 16'h0, fw, 1);
    chk("post_rst_drain", out_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_src_b_stage.md
# alu_src_b_stage

Parametrised, registered successor of the ALU operand-B selector for the multicycle datapath. Selects operand B among register B, a configurable constant, four immediate forms and up to two forwarded results, then presents it through a one-stage valid/ready pipeline register with a skid entry, so the ALU can stall without losing operands. It sits between the register-file/immediate extension logic and the ALU B input.

## Interface
- WIDTH, 32, datapath width in bits (must be ≥ IMM_WIDTH + 2)
- IMM_WIDTH, 16, raw immediate width
- CONST_VAL, 4, constant delivered for select 001 (PC + 4 increment)
- NUM_FWD, 2, forwarding sources present, legal range 0..2
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  reset; asynchronous and active-low
- sel  input  3  source select, sampled with in_valid
- reg_b  input  WIDTH  register B value
- imm  input  IMM_WIDTH  raw instruction immediate
- fwd_data  input  2*WIDTH  forwarded results; fwd 0 in bits [WIDTH-1:0], fwd 1 in bits [2*WIDTH-1:WIDTH]
- in_valid  input  1  producer offers operand
- in_ready  output  1  stage can accept; registered
- out_data  output  WIDTH  selected operand B
- out_sel  output  3  sel value that produced out_data
- out_valid  output  1  out_data valid
- out_ready  input  1  ALU consumes operand
- sel_err  output  1  sticky: an accepted transfer used an absent forwarding source

## Operation
- Select encoding: 000 reg_b; 001 CONST_VAL; 010 sign-extended imm; 011 sign-extended imm << 2 (branch offset); 100 zero-extended imm; 101 imm << 16 in low half zero (upper-immediate form); 110 fwd 0; 111 fwd 1.
- Extension and shifts are computed at WIDTH; bits shifted above WIDTH-1 are discarded; shifted-in bits are 0.
- Select 110 with NUM_FWD < 1, or 111 with NUM_FWD < 2: operand is 0, transfer still completes, sel_err set.
- Input transfer: in_valid & in_ready at an edge. Output transfer: out_valid & out_ready at an edge.
- Storage: main register (drives outputs) plus one skid entry. States: EMPTY (no data), HALF (main only), FULL (main + skid).
- EMPTY: input transfer → HALF, main loaded.
- HALF: input without output transfer → FULL, skid loaded; output without input → EMPTY; both → stays HALF, main reloaded with new operand.
- FULL: in_ready low, no input accepted; output transfer → HALF, skid moves to main.
- Ordering strictly FIFO; no operand is dropped or duplicated.
- in_valid while in_ready is low is ignored; the producer must hold data and in_valid until accepted.
- sel_err clears only on reset.

## Timing
- Latency: operand accepted at edge N appears on out_data with out_valid high after edge N (one cycle).
- Throughput: one operand per cycle while out_ready is high.
- in_ready = state ≠ FULL, taken from registers (no combinational path from out_ready to in_ready).
- Reset (asserted at any time, including mid-transfer): state EMPTY, out_valid 0, in_ready 1, out_data 0, out_sel 000, skid contents 0, sel_err 0; takes effect immediately without a clock.
- First edge after reset release may accept an operand.
- out_data/out_sel hold stable while out_valid & !out_ready.

## Structure
- Shared package alu_src_b_pkg: 3-bit select codes (SRC_B_REG, SRC_B_CONST, SRC_B_SEXT, SRC_B_SEXT_SL2, SRC_B_ZEXT, SRC_B_LUI, SRC_B_FWD0, SRC_B_FWD1) and state encoding; the control unit imports the same codes.
- One sub-module: pipe_skid_buffer (parameter DATA_WIDTH), generic valid/ready main+skid register; alu_src_b_stage instantiates it with DATA_WIDTH = WIDTH + 3 (operand + sel). Selection/extension logic stays combinational in the top.

## Test plan
- Select sweep, WIDTH 32: imm 0x8001 → 010 gives 0xFFFF8001, 011 gives 0xFFFE0004, 100 gives 0x00008001, 101 gives 0x80010000; 001 gives 0x00000004; 000 returns reg_b; all one cycle after acceptance.
- Streaming: out_ready held 1, 8 back-to-back operands → 8 outputs in order on consecutive cycles, in_ready never drops.
- Backpressure: out_ready 0, offer A, B, C → A on output, B in skid, in_ready 0 after second acceptance, C held; raise out_ready → A, B, C delivered in order, none lost.
- NUM_FWD 1: sel 111 accepted → out_data 0, sel_err 1 and remains 1 through later legal transfers; sel 110 returns fwd 0.
- Reset in FULL state with out_ready 0: reset low mid-cycle → out_valid 0, in_ready 1, sel_err 0 immediately; after release first operand emerges after one cycle.
- Simultaneous in/out transfer in HALF: out_ready 1 and new operand same edge → state stays HALF, out_data updates to new operand next cycle.
